// File: rtl/usb_pkt_serializer.sv
// usb_pkt_serializer
//   Takes one packet descriptor at a time and sends it one line bit per clock:
//   SYNC, PID, optional body, optional CRC5/CRC16, then EOP. The CRC is worked
//   out while the body is being sent. Stuff bits and NRZI coding are added
//   on the way out.
// Ports
//   clk, rst_b            clock, asynchronous active-low reset
//   pkt_valid/pkt_ready   descriptor handshake (pkt_ready = idle)
//   pkt_type, pid         00 handshake, 01 token, 10 data, 11 reserved; PID nibble
//   payload, len          token {endp,addr} in [10:0]; data bytes LSB-first, len bytes
//   tx_en, tx_bit, tx_eop line enable, line level (J = 1), SE0 phase of EOP
//   err                   one-cycle pulse when a descriptor is dropped
// Token packets read payload[10:0], so MAX_BYTES must be at least 2.
//
// state  | meaning
// IDLE   | ready for a descriptor
// DROP   | descriptor rejected, err pulse, line stays off
// SYNC   | 0000000 then 1
// PID    | pid[0..3] then ~pid[0..3]
// BODY   | token address/endpoint or data bytes, CRC updated per bit
// CRC    | inverted CRC, MSB first
// EOP    | trailing stuff bit if one is due, then SE0, SE0, J
module usb_pkt_serializer #(
  parameter int MAX_BYTES = 8,
  parameter bit STUFF_EN  = 1'b1,
  parameter bit NRZI_EN   = 1'b1,
  parameter int LW        = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  input  logic [1:0]             pkt_type,
  input  logic [3:0]             pid,
  input  logic [8*MAX_BYTES-1:0] payload,
  input  logic [LW-1:0]          len,
  output logic                   tx_en,
  output logic                   tx_bit,
  output logic                   tx_eop,
  output logic                   err
);

  localparam int PW = 8 * MAX_BYTES;
  localparam int CW = LW + 3;  // holds 8*len, 11 and 15

  localparam logic [1:0] T_HS   = 2'b00;
  localparam logic [1:0] T_TOK  = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_DROP, S_SYNC, S_PID, S_BODY, S_CRC, S_EOP
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      type_q, type_d;
  logic [3:0]      pid_q, pid_d;
  logic [PW-1:0]   pay_q, pay_d;
  logic [LW-1:0]   len_q, len_d;
  logic [15:0]     crc_q, crc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      ones_q, ones_d;
  logic            lvl_q, lvl_d;

  logic            is_tok;
  logic            crc_msb;
  logic [15:0]     poly;
  logic [CW-1:0]   body_bits;
  logic [CW-1:0]   crc_last;
  logic            stuff_now;
  logic            emit;
  logic            raw;
  logic            fb;
  logic            line_bit;
  logic            line_lvl;

  // Token CRC5 lives in crc_q[4:0]; the upper bits are don't-care then.
  assign is_tok    = (type_q == T_TOK);
  assign crc_msb   = is_tok ? crc_q[4] : crc_q[15];
  assign poly      = is_tok ? 16'h0005 : 16'h8005;
  assign body_bits = is_tok ? CW'(11) : {len_q, 3'b000};
  assign crc_last  = is_tok ? CW'(4) : CW'(15);

  // A stuff bit replaces the next raw bit whenever six 1s have just gone out;
  // the first EOP cycle can still carry one left over from the last CRC bit.
  assign stuff_now = STUFF_EN && (ones_q == 3'd6) &&
                     ((state_q inside {S_SYNC, S_PID, S_BODY, S_CRC}) ||
                      ((state_q == S_EOP) && (cnt_q == '0)));

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    pid_d     = pid_q;
    pay_d     = pay_q;
    len_d     = len_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    lvl_d     = lvl_q;
    emit      = 1'b0;
    raw       = 1'b0;
    fb        = 1'b0;
    line_bit  = 1'b0;
    line_lvl  = 1'b1;
    pkt_ready = 1'b0;
    err       = 1'b0;
    tx_en     = 1'b0;
    tx_bit    = 1'b1;
    tx_eop    = 1'b0;

    case (state_q)
      S_IDLE: begin
        pkt_ready = 1'b1;
        if (pkt_valid) begin
          type_d  = pkt_type;
          pid_d   = pid;
          pay_d   = payload;
          len_d   = len;
          crc_d   = '1;
          cnt_d   = '0;
          ones_d  = '0;
          lvl_d   = 1'b1;
          if ((pkt_type == 2'b11) || ((pkt_type == T_DATA) && (len > LW'(MAX_BYTES))))
            state_d = S_DROP;
          else
            state_d = S_SYNC;
        end
      end

      S_DROP: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end

      S_SYNC: begin
        emit = 1'b1;
        if (!stuff_now) begin
          raw   = (cnt_q == CW'(7));
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(7)) begin
            cnt_d   = '0;
            state_d = S_PID;
          end
        end
      end

      S_PID: begin
        emit = 1'b1;
        if (!stuff_now) begin
          raw   = cnt_q[2] ^ pid_q[cnt_q[1:0]];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(7)) begin
            cnt_d = '0;
            if (type_q == T_HS)
              state_d = S_EOP;
            else if ((type_q == T_DATA) && (len_q == '0))
              state_d = S_CRC;
            else
              state_d = S_BODY;
          end
        end
      end

      S_BODY: begin
        emit = 1'b1;
        if (!stuff_now) begin
          raw   = pay_q[0];
          pay_d = pay_q >> 1;
          fb    = crc_msb ^ raw;
          crc_d = {crc_q[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == body_bits - CW'(1)) begin
            cnt_d   = '0;
            state_d = S_CRC;
          end
        end
      end

      S_CRC: begin
        emit = 1'b1;
        if (!stuff_now) begin
          raw   = ~crc_msb;
          crc_d = {crc_q[14:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == crc_last) begin
            cnt_d   = '0;
            state_d = S_EOP;
          end
        end
      end

      S_EOP: begin
        tx_en = 1'b1;
        if (stuff_now) begin
          emit = 1'b1;
        end else begin
          ones_d = '0;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(2)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            tx_eop = 1'b1;
            tx_bit = 1'b0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      line_bit = stuff_now ? 1'b0 : raw;
      if (stuff_now)
        ones_d = '0;
      else
        ones_d = raw ? ones_q + 3'd1 : 3'd0;
      // NRZI: a 0 toggles the level, a 1 holds it.
      line_lvl = line_bit ? lvl_q : ~lvl_q;
      lvl_d    = line_lvl;
      tx_en    = 1'b1;
      tx_bit   = NRZI_EN ? line_lvl : line_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      pid_q   <= '0;
      pay_q   <= '0;
      len_q   <= '0;
      crc_q   <= '1;
      cnt_q   <= '0;
      ones_q  <= '0;
      lvl_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      pid_q   <= pid_d;
      pay_q   <= pay_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      lvl_q   <= lvl_d;
    end
  end

endmodule

// File: tb/tb_usb_pkt_serializer.sv
// tb_usb_pkt_serializer
//   Self-checking bench for usb_pkt_serializer: fixed vectors with hand-derived
//   expectations, hand-written reset and back-to-back sequences, and random
//   descriptor streams compared against a bit-list reference model.
module tb_usb_pkt_serializer;

  localparam int MAXB = 8;
  localparam int LW   = $clog2(MAXB + 1);
  localparam int PW   = 8 * MAXB;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          pkt_valid = 1'b0;
  logic          pkt_ready;
  logic [1:0]    pkt_type = 2'b00;
  logic [3:0]    pid = 4'h0;
  logic [PW-1:0] payload = '0;
  logic [LW-1:0] len = '0;
  logic          tx_en, tx_bit, tx_eop, err;

  usb_pkt_serializer #(.MAX_BYTES(MAXB), .STUFF_EN(1'b1), .NRZI_EN(1'b1)) dut (
    .clk(clk), .rst_b(rst_b), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_type(pkt_type), .pid(pid), .payload(payload), .len(len),
    .tx_en(tx_en), .tx_bit(tx_bit), .tx_eop(tx_eop), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic en; logic bt; logic eop; logic er; logic rdy;
  } obs_t;

  typedef struct {
    logic [1:0]    typ;
    logic [3:0]    pid;
    logic [PW-1:0] pl;
    logic [LW-1:0] len;
  } desc_t;

  typedef struct {
    desc_t       d;
    int          exp_cycles;  // -1: length not fixed by hand
    int          exp_err;
    int          raw_lo;
    int          raw_n;
    logic [31:0] raw_exp;     // first raw bit in bit raw_n-1
  } vec_t;

  obs_t  exp_q[$];
  obs_t  got_q[$];
  desc_t dq[$];
  int    checks = 0;
  int    errors = 0;

  function automatic obs_t mk(input logic en, input logic bt, input logic eop,
                              input logic er, input logic rdy);
    obs_t o;
    o.en = en; o.bt = bt; o.eop = eop; o.er = er; o.rdy = rdy;
    return o;
  endfunction

  function automatic desc_t mkd(input logic [1:0] t, input logic [3:0] p,
                                input logic [PW-1:0] pl, input logic [LW-1:0] l);
    desc_t d;
    d.typ = t; d.pid = p; d.pl = pl; d.len = l;
    return d;
  endfunction

  // Reference model: build the raw bit list, stuff it, NRZI it, append EOP and
  // the idle cycle that follows every packet.
  function automatic void model_append(input desc_t d);
    bit raw[$];
    bit st[$];
    int nb, w, crc, poly, ones;
    bit lvl, b, fb;
    if (d.typ == 2'b11 || (d.typ == 2'b10 && int'(d.len) > MAXB)) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
      return;
    end
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    for (int i = 0; i < 4; i++) raw.push_back(d.pid[i]);
    for (int i = 0; i < 4; i++) raw.push_back(!d.pid[i]);
    if (d.typ != 2'b00) begin
      w    = (d.typ == 2'b01) ? 5 : 16;
      poly = (d.typ == 2'b01) ? 'h05 : 'h8005;
      nb   = (d.typ == 2'b01) ? 11 : 8 * int'(d.len);
      crc  = (1 << w) - 1;
      for (int i = 0; i < nb; i++) begin
        b = d.pl[i];
        raw.push_back(b);
        fb  = crc[w-1] ^ b;
        crc = ((crc << 1) & ((1 << w) - 1)) ^ (fb ? poly : 0);
      end
      for (int i = w - 1; i >= 0; i--) raw.push_back(!crc[i]);
    end
    ones = 0;
    foreach (raw[i]) begin
      st.push_back(raw[i]);
      if (raw[i]) ones++; else ones = 0;
      if (ones == 6) begin
        st.push_back(1'b0);
        ones = 0;
      end
    end
    lvl = 1'b1;
    foreach (st[i]) begin
      if (!st[i]) lvl = !lvl;
      exp_q.push_back(mk(1'b1, lvl, 1'b0, 1'b0, 1'b0));
    end
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
  endfunction

  task automatic drive(input desc_t d);
    pkt_type = d.typ;
    pid      = d.pid;
    payload  = d.pl;
    len      = d.len;
  endtask

  // Present dq with pkt_valid held until every descriptor is accepted and
  // record exp_q.size() cycles, starting with the cycle after the first accept.
  task automatic run_stream();
    int   k;
    int   ncyc;
    logic rdy;
    ncyc = exp_q.size();
    got_q.delete();
    @(negedge clk);
    k = 0;
    drive(dq[0]);
    pkt_valid = 1'b1;
    rdy = pkt_ready;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      if (pkt_valid && rdy) begin
        k++;
        if (k < dq.size()) drive(dq[k]);
        else pkt_valid = 1'b0;
      end
      @(negedge clk);
      got_q.push_back(mk(tx_en, tx_bit, tx_eop, err, pkt_ready));
      rdy = pkt_ready;
    end
    pkt_valid = 1'b0;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic cmp_trace(input string nm);
    int bad;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      if (bad < got_q.size())
        $display("FAIL %s: cycle %0d {en,bit,eop,err,rdy} got %b expected %b",
                 nm, bad + 1, got_q[bad], exp_q[bad]);
      else
        $display("FAIL %s: trace short, got %0d cycles expected %0d",
                 nm, got_q.size(), exp_q.size());
    end
  endtask

  // Undo NRZI on the captured line: unchanged level = raw 1.
  function automatic logic raw_at(input int i);
    logic prev;
    prev = (i == 0) ? 1'b1 : got_q[i-1].bt;
    return got_q[i].bt == prev;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vt[7];
    int          n, a, b, errs;
    logic [31:0] g;
    string       nm;

    vt[0] = '{mkd(2'b00, 4'h2, '0, '0), 19, 0, 0, 16, 32'b0000000101001011};
    vt[1] = '{mkd(2'b01, 4'hD, '0, '0), 35, 0, 27, 5, 32'b01000};
    vt[2] = '{mkd(2'b10, 4'h3, '0, '0), 35, 0, 16, 16, 32'h0};
    vt[3] = '{mkd(2'b10, 4'hB, PW'(16'hFFFF), LW'(2)), 56, 0, 16, 18,
              32'b111111011111101111};
    vt[4] = '{mkd(2'b11, 4'h5, '0, LW'(3)), 0, 1, 0, 0, 32'h0};
    vt[5] = '{mkd(2'b10, 4'h3, '0, LW'(MAXB + 1)), 0, 1, 0, 0, 32'h0};
    vt[6] = '{mkd(2'b10, 4'h3, PW'(64'h0123456789ABCDEF), LW'(MAXB)), -1, 0, 16, 9,
              32'b111100111};

    // Reset values, before and after clock edges.
    #1;
    check("reset_state", {27'b0, pkt_ready, tx_en, tx_bit, tx_eop, err}, 32'b10100);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", {27'b0, pkt_ready, tx_en, tx_bit, tx_eop, err}, 32'b10100);
    @(negedge clk);
    rst_b = 1'b1;

    // Fixed vectors.
    for (int v = 0; v < 7; v++) begin
      dq.delete();
      dq.push_back(vt[v].d);
      exp_q.delete();
      model_append(vt[v].d);
      run_stream();
      cmp_trace($sformatf("vec%0d_wave", v));
      n = 0;
      while (n < got_q.size() && got_q[n].en) n++;
      errs = 0;
      foreach (got_q[i]) if (got_q[i].er) errs++;
      check($sformatf("vec%0d_err_pulses", v), errs, vt[v].exp_err);
      if (vt[v].exp_cycles >= 0) begin
        check($sformatf("vec%0d_length", v), n, vt[v].exp_cycles);
        a = (vt[v].exp_err != 0) ? 1 : vt[v].exp_cycles;
        if (a < got_q.size())
          check($sformatf("vec%0d_ready_back", v), got_q[a].rdy, 1);
      end
      if (vt[v].exp_cycles >= 3 && vt[v].exp_cycles <= got_q.size()) begin
        a = vt[v].exp_cycles;
        check($sformatf("vec%0d_eop", v),
              {got_q[a-3].eop, got_q[a-2].eop, got_q[a-1].eop}, 32'b110);
      end
      if (vt[v].raw_n > 0) begin
        g = '0;
        for (int j = 0; j < vt[v].raw_n; j++)
          if (vt[v].raw_lo + j < got_q.size()) g = {g[30:0], raw_at(vt[v].raw_lo + j)};
        check($sformatf("vec%0d_raw_bits", v), g, vt[v].raw_exp);
      end
    end

    // Back-to-back with pkt_valid held: token, reserved type, ACK.
    dq.delete();
    dq.push_back(mkd(2'b01, 4'h1, PW'(11'h5A3), '0));
    dq.push_back(mkd(2'b11, 4'h9, '0, '0));
    dq.push_back(mkd(2'b00, 4'h2, '0, '0));
    exp_q.delete();
    foreach (dq[i]) model_append(dq[i]);
    run_stream();
    cmp_trace("b2b_wave");
    errs = 0;
    foreach (got_q[i]) if (got_q[i].er) errs++;
    check("b2b_err_pulses", errs, 1);
    a = 0;
    while (a < got_q.size() && got_q[a].en) a++;
    b = a;
    while (b < got_q.size() && !got_q[b].en) b++;
    check("b2b_gap_cycles", b - a, 3);

    // Reset in the middle of an 8-byte data packet, then a clean ACK.
    @(negedge clk);
    drive(mkd(2'b10, 4'h3, {$urandom, $urandom}, LW'(MAXB)));
    pkt_valid = 1'b1;
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    repeat (39) @(negedge clk);
    check("mid_pkt_active", tx_en, 1);
    @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    check("reset_mid_pkt", {27'b0, pkt_ready, tx_en, tx_bit, tx_eop, err}, 32'b10100);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    dq.delete();
    dq.push_back(mkd(2'b00, 4'h2, '0, '0));
    exp_q.delete();
    model_append(dq[0]);
    run_stream();
    cmp_trace("ack_after_reset");

    // Random descriptor streams.
    for (int batch = 0; batch < 10; batch++) begin
      dq.delete();
      for (int i = 0; i < 5; i++) begin
        desc_t d;
        int    r;
        r = $urandom_range(0, 9);
        d.typ = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        d.pid = 4'($urandom);
        d.pl  = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) d.pl = d.pl | {$urandom, $urandom} | {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) d.pl = '1;
        if ($urandom_range(0, 7) == 0) d.len = LW'($urandom_range(MAXB + 1, (1 << LW) - 1));
        else d.len = LW'($urandom_range(0, MAXB));
        dq.push_back(d);
      end
      exp_q.delete();
      foreach (dq[i]) model_append(dq[i]);
      run_stream();
      nm = $sformatf("rand_batch%0d", batch);
      cmp_trace(nm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_pkt_serializer.md
# usb_pkt_serializer

Parametrised USB transmit serializer: accepts one packet descriptor (type, PID, payload), then emits it one bit per clock as SYNC, PID, body and CRC. CRC5 or CRC16 is computed on the fly during transmission, with no separate calculation pass. Bit stuffing, NRZI encoding and EOP generation are included. Sits between the protocol FSM (descriptor producer) and the line-driver wrapper; it supersedes the fixed-size encoder and adds variable-length data, stuffing and line coding.

## Interface
- MAX_BYTES, 8: maximum DATA payload in bytes.
- STUFF_EN, 1: 1 = insert stuff bits; 0 = no stuffing.
- NRZI_EN, 1: 1 = NRZI-encode tx_bit; 0 = raw bitstream on tx_bit.
- LW, $clog2(MAX_BYTES+1): width of len (derived).

Ports:
- clk  in  1  sole clock.
- rst_b  in  1  asynchronous, active-low reset.
- pkt_valid  in  1  descriptor present.
- pkt_ready  out  1  block idle; a descriptor is accepted on a posedge with pkt_valid && pkt_ready.
- pkt_type  in  2  00 handshake, 01 token, 10 data, 11 reserved.
- pid  in  4  PID nibble.
- payload  in  8*MAX_BYTES  token: [10:0] = {endp,addr}; data: byte k = payload[8k+7:8k].
- len  in  LW  data byte count, 0..MAX_BYTES.
- tx_en  out  1  line driven.
- tx_bit  out  1  line level (J = 1).
- tx_eop  out  1  SE0 phase of EOP.
- err  out  1  one-cycle pulse when a descriptor is dropped.

## Operation
- Reset values: pkt_ready=1, tx_en=0, tx_bit=1, tx_eop=0, err=0, FSM=IDLE, NRZI level=1.
- Accept latches pid, type, payload and len. Inputs are don't-care until the next accept.
- Drop: type 11, or type 10 with len>MAX_BYTES. The descriptor is accepted, err pulses the next cycle, and no bits are emitted.
- FSM states: IDLE -> SYNC(8) -> PID(8) -> BODY -> CRC -> EOP(3) -> IDLE.
  - Handshake skips BODY and CRC.
  - Token BODY is 11 bits, CRC is 5 bits.
  - Data BODY is 8*len bits (0 = skip), CRC is 16 bits.
- Raw bit order:
  - SYNC is 0000000 then 1.
  - PID is pid[0..3] then ~pid[0..3].
  - Body is LSB-first: payload[0] first for token; byte 0 LSB first for data.
- CRC:
  - Register W bits, preset all ones at accept.
  - Updated on each raw BODY bit only: fb = crc[W-1]^b; crc = {crc[W-2:0],0} ^ (fb ? POLY : 0).
  - POLY is 5'h05 for token, 16'h8005 for data.
  - Transmitted as ~crc[W-1] down to ~crc[0].
- Stuffing (STUFF_EN=1):
  - A ones counter is cleared at accept and counts raw 1s from SYNC through the last CRC bit.
  - After the 6th consecutive 1, a 0 is inserted and the counter clears.
  - The raw stream stalls one cycle per stuff bit; the CRC is not updated on stuff bits.
  - A stuff bit that falls after the final CRC bit is still sent.
- NRZI (NRZI_EN=1): a 0 toggles the level, a 1 holds it. The level is reset to 1 at each accept.
- EOP: two cycles of tx_eop=1, tx_bit=0, then one cycle of J (tx_bit=1, tx_eop=0). tx_en=1 throughout all three.

## Timing
- Accept at edge T: first SYNC bit appears on tx_bit/tx_en during T+1. pkt_ready=0 from T+1.
- One line bit per clock; no backpressure.
- Cycles from T+1 to the last J cycle, with S = number of stuff bits:
  - Handshake: 19.
  - Token: 35+S.
  - Data: 35+8*len+S.
- pkt_ready=1 in the cycle after the J cycle. With pkt_valid held high, the next packet is accepted at that edge, giving one idle cycle between packets (tx_en=0, tx_bit=1).
- Drop: pkt_ready=0 for exactly one cycle (T+1, the err cycle), and tx_en stays 0.
- rst_b low at any time, including mid-packet: all outputs take reset values immediately and asynchronously. The partial packet is abandoned, and the first packet after release starts with a fresh CRC preset, ones counter and NRZI level.

## Test plan
- ACK: type 00, pid 4'h2 -> raw bits 00000001 0100 1011; 19 cycles; NRZI levels match the model; pkt_ready back at T+20.
- SETUP token: pid 4'hD, payload[10:0]=0 -> the 5 CRC bits on the wire (raw) are 0,1,0,0,0; 35 cycles total.
- Zero-length DATA0: pid 4'h3, len 0 -> 16 raw CRC bits all 0; 35 cycles; tx_eop high in cycles 33–34.
- DATA1, len 2, bytes FF FF, STUFF_EN=1 -> exactly 2 stuff zeros inside the payload (after payload 1s #6 and #12). Total length is 51+S, and the bitstream matches the software CRC16/stuff/NRZI model.
- rst_b pulsed low at cycle 40 of an 8-byte DATA packet -> outputs idle in the same cycle. The next ACK after release is bit-exact to the standalone ACK case.
- Back-to-back with pkt_valid held: token, then type 11, then ACK -> token ends, err pulses once with no tx_en, and the ACK follows with the documented gap cycles.
